// File: rtl/gcd_entry_sequencer_pkg.sv
// Shared definitions for the calculator GCD front end: key codes, result
// error codes and the sequencer state encoding.
package gcd_entry_sequencer_pkg;

  localparam int DW_DEFAULT = 4;

  typedef enum logic [1:0] {
    KEY_DIGIT = 2'b00,
    KEY_ENTER = 2'b01,
    KEY_CLEAR = 2'b10,
    KEY_RSVD  = 2'b11
  } key_type_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_OVF     = 2'b01,
    ERR_ZERO    = 2'b10,
    ERR_TIMEOUT = 2'b11
  } res_err_e;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_RUN     = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_PRESENT = 3'd4
  } state_e;

  function automatic logic is_entry_state(input state_e s);
    return (s == ST_ENTER_A) || (s == ST_ENTER_B);
  endfunction

endpackage

// File: rtl/gcd_entry_sequencer_dec_accumulator.sv
// Decimal digit accumulator shared by both operands: value, digit count and
// sticky overflow flag.
module gcd_entry_sequencer_dec_accumulator #(
  parameter int DW         = 4,
  parameter int MAX_DIGITS = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          load,
  input  logic [3:0]    digit,
  output logic [DW-1:0] value,
  output logic          ovf
);

  localparam int         CW      = $clog2(MAX_DIGITS + 1);
  localparam logic [7:0] MAX_VAL = 8'((1 << DW) - 1);

  logic [DW-1:0] acc_d, acc_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          ovf_d, ovf_q;
  logic [7:0]    next_s;

  // next accumulator value; once overflowed, digits are swallowed
  always_comb begin
    next_s = 8'(acc_q) * 8'd10 + {4'd0, digit};
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (load && !ovf_q) begin
      if ((digit > 4'd9) || (next_s > MAX_VAL) || (cnt_q == CW'(MAX_DIGITS))) begin
        ovf_d = 1'b1;
      end else begin
        acc_d = next_s[DW-1:0];
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // accumulator state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign value = acc_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/gcd_entry_sequencer.sv
// Keypad front end for the GCD engine: collects two decimal operands, runs the
// engine with a timeout, and presents the result until acknowledged.
module gcd_entry_sequencer
  import gcd_entry_sequencer_pkg::*;
#(
  parameter int DW         = DW_DEFAULT,
  parameter int MAX_DIGITS = 2,
  parameter int TIMEOUT    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_valid,
  input  logic [1:0]    key_type,
  input  logic [3:0]    key_digit,
  output logic          key_ready,
  output logic          gcd_start,
  output logic [DW-1:0] gcd_a,
  output logic [DW-1:0] gcd_b,
  input  logic          gcd_done,
  input  logic [DW-1:0] gcd_result,
  input  logic          gcd_error,
  output logic          res_valid,
  output logic [DW-1:0] res_value,
  output logic [1:0]    res_err,
  input  logic          res_ack
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e        state_d, state_q;
  logic          key_ready_d, key_ready_q;
  logic          gcd_start_d, gcd_start_q;
  logic [DW-1:0] gcd_a_d, gcd_a_q, gcd_b_d, gcd_b_q;
  logic          res_valid_d, res_valid_q;
  logic [DW-1:0] res_value_d, res_value_q;
  logic [1:0]    res_err_d, res_err_q;
  logic [TW-1:0] tmo_d, tmo_q;

  key_type_e     key_type_s;
  logic          key_take_s, acc_clear_s, acc_load_s, acc_ovf_s;
  logic [DW-1:0] acc_value_s;

  assign key_type_s  = key_type_e'(key_type);
  assign key_take_s  = key_valid && key_ready_q;
  assign acc_clear_s = key_take_s && ((key_type_s == KEY_ENTER) || (key_type_s == KEY_CLEAR));
  assign acc_load_s  = key_take_s && (key_type_s == KEY_DIGIT);

  gcd_entry_sequencer_dec_accumulator #(.DW(DW), .MAX_DIGITS(MAX_DIGITS)) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (acc_clear_s),
    .load  (acc_load_s),
    .digit (key_digit),
    .value (acc_value_s),
    .ovf   (acc_ovf_s)
  );

  // sequencer next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    gcd_start_d = gcd_start_q;
    gcd_a_d     = gcd_a_q;
    gcd_b_d     = gcd_b_q;
    res_valid_d = res_valid_q;
    res_value_d = res_value_q;
    res_err_d   = res_err_q;
    tmo_d       = tmo_q;
    case (state_q)
      ST_ENTER_A, ST_ENTER_B: begin
        if (key_take_s) begin
          case (key_type_s)
            KEY_ENTER: begin
              if (acc_ovf_s) begin
                state_d     = ST_PRESENT;
                res_valid_d = 1'b1;
                res_value_d = '0;
                res_err_d   = ERR_OVF;
              end else if (state_q == ST_ENTER_A) begin
                gcd_a_d = acc_value_s;
                state_d = ST_ENTER_B;
              end else begin
                gcd_b_d     = acc_value_s;
                gcd_start_d = 1'b1;
                tmo_d       = '0;
                state_d     = ST_RUN;
              end
            end
            KEY_CLEAR: begin
              gcd_a_d = '0;
              state_d = ST_ENTER_A;
            end
            default: state_d = state_q;
          endcase
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        // done takes priority over a coincident timeout
        if (gcd_done) begin
          res_value_d = gcd_result;
          res_err_d   = gcd_error ? ERR_ZERO : ERR_NONE;
          gcd_start_d = 1'b0;
          state_d     = ST_DRAIN;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          res_value_d = '0;
          res_err_d   = ERR_TIMEOUT;
          gcd_start_d = 1'b0;
          state_d     = ST_DRAIN;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_DRAIN: begin
        if (!gcd_done) begin
          res_valid_d = 1'b1;
          state_d     = ST_PRESENT;
        end else begin
          state_d = state_q;
        end
      end
      ST_PRESENT: begin
        if (res_ack) begin
          res_valid_d = 1'b0;
          gcd_a_d     = '0;
          gcd_b_d     = '0;
          state_d     = ST_ENTER_A;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        gcd_start_d = 1'b0;
        res_valid_d = 1'b0;
        state_d     = ST_ENTER_A;
      end
    endcase
    key_ready_d = is_entry_state(state_d);
  end

  // sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ENTER_A;
      key_ready_q <= 1'b0;
      gcd_start_q <= 1'b0;
      gcd_a_q     <= '0;
      gcd_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_value_q <= '0;
      res_err_q   <= 2'b00;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      key_ready_q <= key_ready_d;
      gcd_start_q <= gcd_start_d;
      gcd_a_q     <= gcd_a_d;
      gcd_b_q     <= gcd_b_d;
      res_valid_q <= res_valid_d;
      res_value_q <= res_value_d;
      res_err_q   <= res_err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign key_ready = key_ready_q;
  assign gcd_start = gcd_start_q;
  assign gcd_a     = gcd_a_q;
  assign gcd_b     = gcd_b_q;
  assign res_valid = res_valid_q;
  assign res_value = res_value_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_gcd_entry_sequencer.sv
// Scoreboard bench for gcd_entry_sequencer with a behavioural GCD engine.
module tb_gcd_entry_sequencer;
  import gcd_entry_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [1:0] key_type = 2'b00;
  logic [3:0] key_digit = 4'd0;
  logic       res_ack = 1'b0;
  logic       key_ready, gcd_start, res_valid;
  logic [3:0] gcd_a, gcd_b, res_value;
  logic [1:0] res_err;
  logic       gcd_done, gcd_error;
  logic [3:0] gcd_result;

  typedef struct packed {
    logic [3:0] value;
    logic [1:0] err;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  bit eng_hang = 1'b0;
  int eng_cnt, drain_cnt;
  int start_rises = 0;

  always #5 clk = ~clk;

  gcd_entry_sequencer #(.DW(4), .MAX_DIGITS(2), .TIMEOUT(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_type   (key_type),
    .key_digit  (key_digit),
    .key_ready  (key_ready),
    .gcd_start  (gcd_start),
    .gcd_a      (gcd_a),
    .gcd_b      (gcd_b),
    .gcd_done   (gcd_done),
    .gcd_result (gcd_result),
    .gcd_error  (gcd_error),
    .res_valid  (res_valid),
    .res_value  (res_value),
    .res_err    (res_err),
    .res_ack    (res_ack)
  );

  // {error, result} the engine should produce for operands a, b
  function automatic logic [4:0] engine_ref(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] x, y, t;
    x = a;
    y = b;
    if (a == 4'd0 && b == 4'd0) return {1'b1, 4'hF};
    while (y != 4'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return {1'b0, x};
  endfunction

  // engine model: done 4 cycles after start, held 3 cycles after start falls
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcd_done   <= 1'b0;
      gcd_error  <= 1'b0;
      gcd_result <= 4'd0;
      eng_cnt    <= 0;
      drain_cnt  <= 0;
    end else if (gcd_start && !gcd_done) begin
      drain_cnt <= 0;
      if (!eng_hang) begin
        if (eng_cnt == 3) begin
          gcd_done   <= 1'b1;
          gcd_error  <= engine_ref(gcd_a, gcd_b) >> 4;
          gcd_result <= engine_ref(gcd_a, gcd_b) & 5'h0F;
          eng_cnt    <= 0;
        end else begin
          eng_cnt <= eng_cnt + 1;
        end
      end
    end else if (!gcd_start && gcd_done) begin
      eng_cnt <= 0;
      if (drain_cnt == 2) begin
        gcd_done  <= 1'b0;
        drain_cnt <= 0;
      end else begin
        drain_cnt <= drain_cnt + 1;
      end
    end
  end

  always @(posedge gcd_start) start_rises <= start_rises + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] value, input logic [1:0] err);
    exp_t e;
    e.value = value;
    e.err   = err;
    sb.push_back(e);
  endtask

  task automatic push_run(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] r;
    r = engine_ref(a, b);
    push_exp(r[3:0], r[4] ? 2'b10 : 2'b00);
  endtask

  task automatic press(input logic [1:0] t, input logic [3:0] d);
    int n = 0;
    @(negedge clk);
    while (!key_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!key_ready) check_eq("key_ready_wait", 32'(key_ready), 32'd1);
    key_valid = 1'b1;
    key_type  = t;
    key_digit = d;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_type  = 2'b00;
    key_digit = 4'd0;
  endtask

  // called right after the ENTER_B enter key has been consumed
  task automatic run_check(input logic [3:0] ea, input logic [3:0] eb, input bit hang);
    int n = 0;
    int done_n = -1;
    int m = 0;
    check_eq("start_lat", 32'(gcd_start), 32'd1);
    check_eq("gcd_a", 32'(gcd_a), 32'(ea));
    check_eq("gcd_b", 32'(gcd_b), 32'(eb));
    while (n < 64) begin
      @(negedge clk);
      if (!gcd_start) break;
      n++;
      if (n == 2) check_eq("key_ready_run", 32'(key_ready), 32'd0);
      if (gcd_done && done_n < 0) done_n = n;
    end
    if (hang) check_eq("run_len", 32'(n), 32'd32);
    else check_eq("done_to_stop", 32'(n), 32'(done_n));
    check_eq("a_hold", 32'(gcd_a), 32'(ea));
    check_eq("b_hold", 32'(gcd_b), 32'(eb));
    if (!hang) begin
      check_eq("drain_hold", 32'(res_valid), 32'd0);
      while (gcd_done && m < 20) begin
        @(negedge clk);
        m++;
      end
      check_eq("drain_exit", 32'(gcd_done), 32'd0);
      check_eq("valid_early", 32'(res_valid), 32'd0);
      check_eq("drain_start", 32'(gcd_start), 32'd0);
      @(negedge clk);
      check_eq("valid_lat", 32'(res_valid), 32'd1);
    end
  endtask

  task automatic wait_result();
    int n = 0;
    exp_t e;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) check_eq("res_valid_wait", 32'(res_valid), 32'd1);
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_eq("res_value", 32'(res_value), 32'(e.value));
      check_eq("res_err", 32'(res_err), 32'(e.err));
    end
    check_eq("key_ready_present", 32'(key_ready), 32'd0);
    res_ack = 1'b1;
    @(posedge clk);
    #1;
    res_ack = 1'b0;
    @(negedge clk);
    check_eq("ack_valid", 32'(res_valid), 32'd0);
    check_eq("ack_clr_a", 32'(gcd_a), 32'd0);
    check_eq("ack_ready", 32'(key_ready), 32'd1);
  endtask

  initial begin
    int base;
    repeat (2) @(negedge clk);
    check_eq("rst_start", 32'(gcd_start), 32'd0);
    check_eq("rst_valid", 32'(res_valid), 32'd0);
    check_eq("rst_ready", 32'(key_ready), 32'd0);
    check_eq("rst_err", 32'(res_err), 32'd0);
    check_eq("rst_a", 32'(gcd_a), 32'd0);
    rst_n = 1'b1;

    // 12 and 8
    press(KEY_DIGIT, 4'd1); press(KEY_DIGIT, 4'd2); press(KEY_ENTER, 4'd0);
    press(KEY_DIGIT, 4'd8); press(KEY_ENTER, 4'd0);
    push_run(4'd12, 4'd8);
    run_check(4'd12, 4'd8, 1'b0);
    wait_result();

    // both operands zero: engine error with result 15
    press(KEY_ENTER, 4'd0); press(KEY_ENTER, 4'd0);
    push_run(4'd0, 4'd0);
    run_check(4'd0, 4'd0, 1'b0);
    wait_result();

    // entry overflows: value too big, too many digits, non-decimal digit
    base = start_rises;
    press(KEY_DIGIT, 4'd1); press(KEY_DIGIT, 4'd7); press(KEY_ENTER, 4'd0);
    push_exp(4'd0, 2'b01);
    wait_result();
    press(KEY_DIGIT, 4'd1); press(KEY_DIGIT, 4'd2); press(KEY_DIGIT, 4'd3);
    press(KEY_ENTER, 4'd0);
    push_exp(4'd0, 2'b01);
    wait_result();
    press(KEY_DIGIT, 4'd3); press(KEY_ENTER, 4'd0);
    press(KEY_DIGIT, 4'd12); press(KEY_ENTER, 4'd0);
    push_exp(4'd0, 2'b01);
    wait_result();
    check_eq("ovf_no_start", 32'(start_rises), 32'(base));

    // engine never answers
    eng_hang = 1'b1;
    press(KEY_DIGIT, 4'd9); press(KEY_ENTER, 4'd0);
    press(KEY_DIGIT, 4'd6); press(KEY_ENTER, 4'd0);
    push_exp(4'd0, 2'b11);
    run_check(4'd9, 4'd6, 1'b1);
    wait_result();
    eng_hang = 1'b0;

    // clear mid-entry, then a clear key offered during RUN must be ignored
    press(KEY_DIGIT, 4'd5); press(KEY_CLEAR, 4'd0);
    press(KEY_DIGIT, 4'd6); press(KEY_ENTER, 4'd0);
    press(KEY_DIGIT, 4'd9); press(KEY_ENTER, 4'd0);
    key_valid = 1'b1;
    key_type  = KEY_CLEAR;
    push_run(4'd6, 4'd9);
    run_check(4'd6, 4'd9, 1'b0);
    key_valid = 1'b0;
    key_type  = 2'b00;
    wait_result();

    // asynchronous reset in the middle of a run
    eng_hang = 1'b1;
    press(KEY_DIGIT, 4'd3); press(KEY_ENTER, 4'd0);
    press(KEY_DIGIT, 4'd4); press(KEY_ENTER, 4'd0);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_start", 32'(gcd_start), 32'd0);
    check_eq("arst_valid", 32'(res_valid), 32'd0);
    check_eq("arst_ready", 32'(key_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    eng_hang = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("post_rst_ready", 32'(key_ready), 32'd1);

    // reserved key is ignored, then a normal run from ENTER_A
    press(KEY_RSVD, 4'd7);
    press(KEY_DIGIT, 4'd2); press(KEY_ENTER, 4'd0);
    press(KEY_DIGIT, 4'd4); press(KEY_ENTER, 4'd0);
    push_run(4'd2, 4'd4);
    run_check(4'd2, 4'd4, 1'b0);
    wait_result();

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
